reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (legal 1..64).
REQ-002 Parameter DEPTH, default 4, number of registers (legal 2..256).
REQ-003 Local parameter AW = clog2(DEPTH), address width in bits.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 wr_en  input  1  write request for the current cycle.
REQ-007 wr_addr  input  AW  write register index.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 rd_addr1, rd_addr2  input  AW each  read port indices.
REQ-010 rd_data1, rd_data2  output  WIDTH each  registered read data.
REQ-011 clr_req  input  1  single-cycle request to clear all registers.
REQ-012 busy  output  1  high while the clear sweep is in progress.

Function
REQ-013 Read latency SHALL be one cycle: rd_dataN after edge k equals the contents of rd_addrN as sampled at edge k.
REQ-014 Both read ports SHALL be independent; equal addresses on both ports are legal and return identical data.
REQ-015 Each read port SHALL bypass the write port: when wr_en is accepted and wr_addr equals rd_addrN in the same cycle, rd_dataN SHALL take wr_data.
REQ-016 An accepted write SHALL update register wr_addr at that edge; all other registers SHALL hold.
REQ-017 Addresses >= DEPTH SHALL be ignored for writes, and SHALL read as zero.
REQ-018 The FSM SHALL have states IDLE and CLEAR, with a sweep counter of width AW.
REQ-019 IDLE: clr_req=1 SHALL load counter=0 and move to CLEAR; busy SHALL rise on the next cycle.
REQ-020 CLEAR: each cycle SHALL write zero to register[counter] and increment counter.
REQ-021 CLEAR SHALL return to IDLE on the cycle that clears index DEPTH-1, giving busy=1 for exactly DEPTH cycles.
REQ-022 wr_en SHALL be ignored (no update, no bypass) while busy=1.
REQ-023 clr_req SHALL be ignored while busy=1.
REQ-024 A write in the same cycle as clr_req in IDLE SHALL be accepted; the sweep later overwrites it with zero.
REQ-025 Reads SHALL remain serviced during CLEAR.
REQ-026 During CLEAR, a read of the index being swept in that cycle SHALL return the pre-clear value; the sweep write is not bypassed.

Reset
REQ-027 With rst=0 at a rising edge, every register SHALL become zero, rd_data1=rd_data2=0, busy=0, FSM=IDLE, and counter=0.
REQ-028 Reset SHALL take priority over wr_en and clr_req, and SHALL abort a sweep in progress with no further sweep writes.
REQ-029 No state SHALL change on an rst edge alone; reset acts only at a clk edge.

Configuration
REQ-030 Macro RF_ZERO_REG_EN, when defined: register 0 SHALL be hardwired to zero, writes to index 0 SHALL be discarded, bypass on index 0 SHALL return zero, and the sweep is unaffected.
REQ-031 Without RF_ZERO_REG_EN, register 0 SHALL be an ordinary register.

Verification
REQ-032 Default parameters, after reset: write 0x5A to reg 2; on the next cycle read rd_addr1=2 -> rd_data1=0x5A one cycle later; rd_addr2=3 -> 0x00.
REQ-033 Same-cycle write 0xC3 to reg 1 with rd_addr1=1 and rd_addr2=1 -> both rd_data ports = 0xC3 after one edge.
REQ-034 Fill regs 0..3 with 0x11,0x22,0x33,0x44, then pulse clr_req -> busy=1 for exactly 4 cycles; a wr_en to reg 1 during CLEAR has no effect; afterwards all regs read 0x00.
REQ-035 Assert rst=0 mid-sweep (second CLEAR cycle) -> next edge busy=0, all regs and rd_data = 0, and no sweep resumes after rst=1.
REQ-036 With RF_ZERO_REG_EN defined: write 0xFF to reg 0 -> reg 0 reads 0x00, including the same-cycle bypass; without the macro, reg 0 reads 0xFF.
REQ-037 WIDTH=16, DEPTH=6: write 0xBEEF to reg 5 -> reads 0xBEEF; write to address 7 -> no register changes and address 7 reads 0x0000; clr_req -> busy=1 for 6 cycles.

Source files
------------

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_param
//  Brief    : Parameterised register file with one write port, two
//             registered read ports with write bypass, and a clear-sweep FSM
//             that zeroes every register one index per cycle.
//  Options  : RF_ZERO_REG_EN - when defined, register 0 is hardwired to zero.
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             clr_req,
  output logic             busy
);

  // One extra bit so DEPTH itself is representable for range checks.
  localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data1;
  logic [WIDTH-1:0] r_rd_data2;

  logic             w_busy;
  logic             w_wr_in_range;
  logic             w_wr_ok;
  logic             w_rd1_in_range;
  logic             w_rd2_in_range;
  logic [WIDTH-1:0] w_rd1_val;
  logic [WIDTH-1:0] w_rd2_val;

  assign w_busy         = (r_state == CLEAR);
  assign w_wr_in_range  = ({1'b0, wr_addr}  < c_depth);
  assign w_rd1_in_range = ({1'b0, rd_addr1} < c_depth);
  assign w_rd2_in_range = ({1'b0, rd_addr2} < c_depth);

  // A write is accepted only outside the sweep and to a real register.
  // With the zero register enabled, index 0 writes are dropped here, which
  // also suppresses their bypass so reads of index 0 stay zero.
`ifdef RF_ZERO_REG_EN
  assign w_wr_ok = wr_en && !w_busy && w_wr_in_range && (wr_addr != '0);
`else
  assign w_wr_ok = wr_en && !w_busy && w_wr_in_range;
`endif

  // Read mux: out-of-range reads return zero; an accepted write to the same
  // index is forwarded. Sweep writes are never forwarded, so a read of the
  // index being cleared returns its old contents.
  always_comb begin
    w_rd1_val = '0;
    w_rd2_val = '0;
    if (w_rd1_in_range) begin
      w_rd1_val = (w_wr_ok && (wr_addr == rd_addr1)) ? wr_data : r_mem[rd_addr1];
    end
    if (w_rd2_in_range) begin
      w_rd2_val = (w_wr_ok && (wr_addr == rd_addr2)) ? wr_data : r_mem[rd_addr2];
    end
  end

  // Clear-sweep next-state: IDLE waits for clr_req, CLEAR walks every index
  // once and leaves on the cycle that clears the last one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (r_cnt == c_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and sweep counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Register array: sweep clear takes the slot during CLEAR, otherwise the
  // accepted write updates its single target and everything else holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_busy && (r_cnt == AW'(i))) begin
          r_mem[i] <= '0;
        end else if (w_wr_ok && (wr_addr == AW'(i))) begin
          r_mem[i] <= wr_data;
        end
      end
    end
  end

  // Registered read data, one cycle after the address is sampled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data1 <= '0;
      r_rd_data2 <= '0;
    end else begin
      r_rd_data1 <= w_rd1_val;
      r_rd_data2 <= w_rd2_val;
    end
  end

  assign rd_data1 = r_rd_data1;
  assign rd_data2 = r_rd_data2;
  assign busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_param
//  Brief    : Scoreboard bench for reg_file_param. Two instances (default
//             8x4 and 16x6) share one stimulus stream; an array model
//             predicts read data and busy, a monitor compares each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_param;

`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, wr_en, clr_req;
  logic [2:0]  wa, ra1, ra2;
  logic [15:0] wd;
  logic [7:0]  a_rd1, a_rd2;
  logic        a_busy;
  logic [15:0] b_rd1, b_rd2;
  logic        b_busy;

  always #5 clk = ~clk;

  reg_file_param u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wa[1:0]), .wr_data(wd[7:0]),
    .rd_addr1(ra1[1:0]), .rd_addr2(ra2[1:0]), .rd_data1(a_rd1), .rd_data2(a_rd2),
    .clr_req(clr_req), .busy(a_busy)
  );

  reg_file_param #(.WIDTH(16), .DEPTH(6)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wa), .wr_data(wd),
    .rd_addr1(ra1), .rd_addr2(ra2), .rd_data1(b_rd1), .rd_data2(b_rd2),
    .clr_req(clr_req), .busy(b_busy)
  );

  typedef struct packed {
    logic [15:0] a1, a2, b1, b2;
    logic        ab, bb;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mdl_mem [2][8];
  int          mdl_left [2];   // sweep cycles still owed by each instance
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int dep_of(input int k);
    return (k == 0) ? 4 : 6;
  endfunction

  function automatic logic [15:0] mask_of(input int k);
    return (k == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  function automatic int addr_of(input int k, input logic [2:0] a);
    return (k == 0) ? int'(a[1:0]) : int'(a);
  endfunction

  // Reference behaviour for one clock edge of instance k.
  task automatic model_step(input int k, output logic [15:0] e1, output logic [15:0] e2,
                            output logic eb);
    int          dep, w, a1, a2;
    logic [15:0] d;
    bit          busy_now, wr_ok;
    dep      = dep_of(k);
    w        = addr_of(k, wa);
    a1       = addr_of(k, ra1);
    a2       = addr_of(k, ra2);
    d        = wd & mask_of(k);
    busy_now = (mdl_left[k] > 0);
    wr_ok    = wr_en && !busy_now && (w < dep);
    if (!rst) begin
      for (int i = 0; i < 8; i++) mdl_mem[k][i] = 16'h0;
      mdl_left[k] = 0;
      e1 = 16'h0; e2 = 16'h0; eb = 1'b0;
    end else begin
      if (a1 >= dep) e1 = 16'h0;
      else if (wr_ok && w == a1) e1 = (ZR && a1 == 0) ? 16'h0 : d;
      else e1 = mdl_mem[k][a1];
      if (a2 >= dep) e2 = 16'h0;
      else if (wr_ok && w == a2) e2 = (ZR && a2 == 0) ? 16'h0 : d;
      else e2 = mdl_mem[k][a2];
      if (busy_now) begin
        mdl_mem[k][dep - mdl_left[k]] = 16'h0;
        mdl_left[k] = mdl_left[k] - 1;
      end else begin
        if (wr_ok && !(ZR && w == 0)) mdl_mem[k][w] = d;
        if (clr_req) mdl_left[k] = dep;
      end
      eb = (mdl_left[k] > 0);
    end
  endtask

  // Drive one cycle of stimulus and queue the predicted response.
  task automatic cycle(input logic r, input logic we, input logic [2:0] aw, input logic [15:0] d,
                       input logic [2:0] r1, input logic [2:0] r2, input logic c);
    exp_t        e;
    logic [15:0] x1, x2;
    logic        xb;
    @(negedge clk);
    rst = r; wr_en = we; wa = aw; wd = d; ra1 = r1; ra2 = r2; clr_req = c;
    model_step(0, x1, x2, xb); e.a1 = x1; e.a2 = x2; e.ab = xb;
    model_step(1, x1, x2, xb); e.b1 = x1; e.b2 = x2; e.bb = xb;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: the DUTs present fresh read data every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("a_rd_data1", {8'h0, a_rd1}, e.a1);
        check("a_rd_data2", {8'h0, a_rd2}, e.a2);
        check("a_busy",     {15'h0, a_busy}, {15'h0, e.ab});
        check("b_rd_data1", b_rd1, e.b1);
        check("b_rd_data2", b_rd2, e.b2);
        check("b_busy",     {15'h0, b_busy}, {15'h0, e.bb});
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      mdl_left[k] = 0;
      for (int i = 0; i < 8; i++) mdl_mem[k][i] = 16'h0;
    end
    rst = 1'b0; wr_en = 1'b0; clr_req = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

    // reset
    cycle(0, 0, 0, 16'h0, 0, 0, 0);
    cycle(0, 1, 1, 16'h77, 1, 2, 1);
    // write then read back, untouched register reads zero
    cycle(1, 1, 2, 16'h005A, 0, 0, 0);
    cycle(1, 0, 0, 16'h0, 2, 3, 0);
    cycle(1, 0, 0, 16'h0, 2, 3, 0);
    // same-cycle bypass on both ports
    cycle(1, 1, 1, 16'h00C3, 1, 1, 0);
    // fill, clear, blocked write during sweep, then read everything
    for (int i = 0; i < 6; i++) cycle(1, 1, 3'(i), 16'(16'h11 * (i + 1)), 3'(i), 3'(i), 0);
    cycle(1, 0, 0, 16'h0, 0, 1, 1);
    for (int i = 0; i < 7; i++) cycle(1, 1, 1, 16'hAB00 + 16'(i), 3'(i % 6), 1, (i == 2));
    for (int i = 0; i < 8; i += 2) cycle(1, 0, 0, 16'h0, 3'(i), 3'(i + 1), 0);
    // reset in the second sweep cycle aborts the clear
    for (int i = 0; i < 6; i++) cycle(1, 1, 3'(i), 16'(16'h0101 * (i + 1)), 0, 0, 0);
    cycle(1, 1, 3, 16'h00EE, 3, 0, 1);
    cycle(1, 0, 0, 16'h0, 0, 1, 0);
    cycle(0, 1, 2, 16'h1234, 2, 3, 1);
    for (int i = 0; i < 8; i += 2) cycle(1, 0, 0, 16'h0, 3'(i), 3'(i + 1), 0);
    // register 0 write and bypass
    cycle(1, 1, 0, 16'h00FF, 0, 0, 0);
    cycle(1, 0, 0, 16'h0, 0, 0, 0);
    // wide instance: top register, out-of-range write and read
    cycle(1, 1, 5, 16'hBEEF, 5, 7, 0);
    cycle(1, 1, 7, 16'h1234, 5, 7, 0);
    cycle(1, 0, 0, 16'h0, 7, 6, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 16'h0, 3'(i), 7, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 19) == 0));
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
